// File: rtl/adc_echo_packer.sv
// adc_echo_packer: frames ADC samples into echoes, packs pairs into
// bus words and buffers them in a first-word-fall-through FIFO.
//
// Ports:
//   ADC_CLK, RESET_N      sole clock, sync active-low reset
//   START                 arm pulse, latches SAMPLES_PER_ECHO/ECHO_PER_SCAN
//   ADC_IN_DATA/VALID     sample stream
//   OUT_DATA/VALID/READY  packed word stream (FIFO head)
//   BUSY, DONE            scan in progress, one-cycle completion pulse
//   OVERFLOW, WORD_COUNT  sticky drop flag, words pushed this scan
module adc_echo_packer #(
  parameter int DATABUS_WIDTH  = 32,
  parameter int ADC_DATA_WIDTH = 16,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                      ADC_CLK,
  input  logic                      RESET_N,
  input  logic                      START,
  input  logic [DATABUS_WIDTH-1:0]  SAMPLES_PER_ECHO,
  input  logic [DATABUS_WIDTH-1:0]  ECHO_PER_SCAN,
  input  logic [ADC_DATA_WIDTH-1:0] ADC_IN_DATA,
  input  logic                      ADC_IN_VALID,
  output logic [DATABUS_WIDTH-1:0]  OUT_DATA,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      OVERFLOW,
  output logic [DATABUS_WIDTH-1:0]  WORD_COUNT
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int DW = DATABUS_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DW-1:0]             r_spe;
  logic [DW-1:0]             r_eps;
  logic [DW-1:0]             r_sample_cnt;
  logic [DW-1:0]             r_echo_cnt;
  logic [ADC_DATA_WIDTH-1:0] r_lo;
  logic                      r_done;
  logic                      r_ovf;
  logic [DW-1:0]             r_wcnt;

  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  logic          w_pop;
  logic          w_full;
  logic          w_drain_empty;
  logic          w_last_s;
  logic          w_last_e;
  logic          w_params_ok;
  logic          w_arm;
  logic          w_nul;
  logic          w_take;
  logic          w_lo_load;
  logic          w_echo_end;
  logic          w_push;
  logic [DW-1:0] w_word;
  logic          w_done_nxt;
  logic          w_push_ok;
  logic          w_drop;

  assign w_pop    = (r_cnt != '0) & OUT_READY;
  assign w_full   = (r_cnt == CW'(FIFO_DEPTH));
  assign w_last_s = (r_sample_cnt == r_spe - 1'b1);
  assign w_last_e = (r_echo_cnt == r_eps - 1'b1);
  assign w_params_ok = (|SAMPLES_PER_ECHO) & (|ECHO_PER_SCAN);

  // nothing is pushed in DRAIN, so only the pop matters here
  assign w_drain_empty = (r_cnt == CW'(w_pop));

  // a full FIFO still takes the word if its head leaves this cycle
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  always_ff @(posedge ADC_CLK) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_nul       = 1'b0;
    w_take      = 1'b0;
    w_lo_load   = 1'b0;
    w_echo_end  = 1'b0;
    w_push      = 1'b0;
    w_word      = '0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (START) begin
          if (w_params_ok) begin
            w_arm       = 1'b1;
            w_state_nxt = ST_LO;
          end else begin
            w_nul      = 1'b1;
            w_done_nxt = 1'b1;
          end
        end
      end
      ST_LO: begin
        if (ADC_IN_VALID) begin
          w_take    = 1'b1;
          w_lo_load = 1'b1;
          if (w_last_s) begin
            // odd-length echo: lone tail sample, upper half zero
            w_push     = 1'b1;
            w_word     = {{ADC_DATA_WIDTH{1'b0}}, ADC_IN_DATA};
            w_echo_end = 1'b1;
            w_state_nxt = w_last_e ? ST_DRAIN : ST_LO;
          end else begin
            w_state_nxt = ST_HI;
          end
        end
      end
      ST_HI: begin
        if (ADC_IN_VALID) begin
          w_take = 1'b1;
          w_push = 1'b1;
          w_word = {ADC_IN_DATA, r_lo};
          if (w_last_s) begin
            w_echo_end  = 1'b1;
            w_state_nxt = w_last_e ? ST_DRAIN : ST_LO;
          end else begin
            w_state_nxt = ST_LO;
          end
        end
      end
      ST_DRAIN: begin
        if (w_drain_empty) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ADC_CLK) begin
    if (!RESET_N) begin
      r_spe        <= '0;
      r_eps        <= '0;
      r_sample_cnt <= '0;
      r_echo_cnt   <= '0;
      r_lo         <= '0;
      r_done       <= 1'b0;
      r_ovf        <= 1'b0;
      r_wcnt       <= '0;
    end else begin
      r_done <= w_done_nxt;
      if (w_arm) begin
        r_spe        <= SAMPLES_PER_ECHO;
        r_eps        <= ECHO_PER_SCAN;
        r_sample_cnt <= '0;
        r_echo_cnt   <= '0;
        r_wcnt       <= '0;
        r_ovf        <= 1'b0;
      end
      if (w_nul) begin
        r_wcnt <= '0;
        r_ovf  <= 1'b0;
      end
      if (w_lo_load) begin
        r_lo <= ADC_IN_DATA;
      end
      if (w_take) begin
        if (w_echo_end) begin
          r_sample_cnt <= '0;
          r_echo_cnt   <= r_echo_cnt + 1'b1;
        end else begin
          r_sample_cnt <= r_sample_cnt + 1'b1;
        end
      end
      // dropped words still count toward the scan total
      if (w_push) begin
        r_wcnt <= r_wcnt + 1'b1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge ADC_CLK) begin
    if (!RESET_N) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      r_cnt <= r_cnt + CW'(w_push_ok) - CW'(w_pop);
    end
  end

  always_ff @(posedge ADC_CLK) begin
    if (w_push_ok) begin
      r_mem[r_wr] <= w_word;
    end
  end

  assign OUT_VALID  = (r_cnt != '0);
  assign OUT_DATA   = OUT_VALID ? r_mem[r_rd] : '0;
  assign BUSY       = (r_state != ST_IDLE);
  assign DONE       = r_done;
  assign OVERFLOW   = r_ovf;
  assign WORD_COUNT = r_wcnt;

endmodule

// File: tb/tb_adc_echo_packer.sv
// Bench for adc_echo_packer: directed scans plus randomized scans
// against a queue-based reference model.
module tb_adc_echo_packer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] spe;
  logic [31:0] eps;
  logic [15:0] din;
  logic        valid;
  logic        ready;
  logic [31:0] o_data;
  logic        o_valid;
  logic        o_busy;
  logic        o_done;
  logic        o_ovf;
  logic [31:0] o_wc;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  logic [31:0] got [$];

  // reference model state
  logic [31:0] mq [$];
  logic [15:0] m_cur [$];
  bit          m_busy;
  bit          m_drain;
  bit          m_done;
  bit          m_ovf;
  int unsigned m_s;
  int unsigned m_e;
  int unsigned m_n;
  int unsigned m_ei;
  logic [31:0] m_wc;

  always #5 clk = ~clk;

  adc_echo_packer #(
    .DATABUS_WIDTH (32),
    .ADC_DATA_WIDTH(16),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .ADC_CLK         (clk),
    .RESET_N         (rst_n),
    .START           (start),
    .SAMPLES_PER_ECHO(spe),
    .ECHO_PER_SCAN   (eps),
    .ADC_IN_DATA     (din),
    .ADC_IN_VALID    (valid),
    .OUT_DATA        (o_data),
    .OUT_VALID       (o_valid),
    .OUT_READY       (ready),
    .BUSY            (o_busy),
    .DONE            (o_done),
    .OVERFLOW        (o_ovf),
    .WORD_COUNT      (o_wc)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  // one clock edge of the specified behaviour
  task automatic model_step();
    bit          pop;
    bit          pw;
    logic [31:0] w;
    pop = ready && (mq.size() > 0);
    pw  = 1'b0;
    w   = '0;
    if (!rst_n) begin
      mq.delete();
      m_cur.delete();
      m_busy  = 1'b0;
      m_drain = 1'b0;
      m_done  = 1'b0;
      m_ovf   = 1'b0;
      m_wc    = '0;
      return;
    end
    m_done = 1'b0;
    if (!m_busy) begin
      if (start) begin
        if (spe != 0 && eps != 0) begin
          m_busy = 1'b1;
          m_s    = spe;
          m_e    = eps;
          m_n    = 0;
          m_ei   = 0;
          m_cur.delete();
          m_wc   = '0;
          m_ovf  = 1'b0;
        end else begin
          m_done = 1'b1;
          m_wc   = '0;
          m_ovf  = 1'b0;
        end
      end
    end else if (!m_drain) begin
      if (valid) begin
        m_cur.push_back(din);
        m_n++;
        if (m_cur.size() == 2) begin
          pw = 1'b1;
          w  = {m_cur[1], m_cur[0]};
          m_cur.delete();
        end
        if (m_n == m_s) begin
          if (m_cur.size() == 1) begin
            pw = 1'b1;
            w  = {16'h0000, m_cur[0]};
          end
          m_cur.delete();
          m_n = 0;
          m_ei++;
          if (m_ei == m_e) m_drain = 1'b1;
        end
      end
    end else begin
      if (mq.size() == int'(pop)) begin
        m_busy  = 1'b0;
        m_drain = 1'b0;
        m_done  = 1'b1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (pw) begin
      m_wc++;
      if (mq.size() < DEPTH) mq.push_back(w);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic compare();
    check("valid", {31'd0, o_valid}, {31'd0, mq.size() != 0});
    if (mq.size() != 0) check("data", o_data, mq[0]);
    else check("data_idle", o_data, 32'd0);
    check("busy", {31'd0, o_busy}, {31'd0, m_busy});
    check("done", {31'd0, o_done}, {31'd0, m_done});
    check("ovf", {31'd0, o_ovf}, {31'd0, m_ovf});
    check("wcount", o_wc, m_wc);
  endtask

  task automatic tick();
    if (o_valid && ready) got.push_back(o_data);
    @(posedge clk);
    model_step();
    #1;
    if (o_done) n_done++;
    compare();
  endtask

  task automatic arm(input logic [31:0] s, input logic [31:0] e);
    spe   = s;
    eps   = e;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] d);
    valid = 1'b1;
    din   = d;
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 3000; k++) begin
      if (n_done != 0) break;
      tick();
    end
    check(tag, {31'd0, n_done != 0}, 32'd1);
  endtask

  initial begin
    logic [31:0] exp1 [4];
    logic [31:0] exp2 [4];
    rst_n = 1'b0;
    start = 1'b0;
    spe   = '0;
    eps   = '0;
    din   = '0;
    valid = 1'b0;
    ready = 1'b0;
    m_busy = 1'b0; m_drain = 1'b0; m_done = 1'b0;
    m_ovf = 1'b0; m_wc = '0;
    m_s = 0; m_e = 0; m_n = 0; m_ei = 0;
    repeat (3) tick();
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_wc", o_wc, 32'd0);
    rst_n = 1'b1;
    tick();

    // S=4 E=2, back-to-back
    exp1 = '{32'h00650064, 32'h00670066,
             32'h00690068, 32'h006B006A};
    got.delete(); n_done = 0; ready = 1'b1;
    arm(4, 2);
    for (int i = 0; i < 8; i++) feed(16'(100 + i));
    wait_done("t1_done");
    repeat (2) tick();
    check("t1_done_cnt", n_done, 1);
    check("t1_nwords", got.size(), 4);
    for (int i = 0; i < 4; i++) check("t1_word", got[i], exp1[i]);
    check("t1_wc", o_wc, 4);

    // S=3 E=2, odd echo tail
    exp2 = '{32'h00020001, 32'h00000003,
             32'h00050004, 32'h00000006};
    got.delete(); n_done = 0;
    arm(3, 2);
    for (int i = 1; i <= 6; i++) feed(16'(i));
    wait_done("t2_done");
    check("t2_nwords", got.size(), 4);
    for (int i = 0; i < 4; i++) check("t2_word", got[i], exp2[i]);

    // S=40 E=1 with the reader stalled
    got.delete(); n_done = 0; ready = 1'b0;
    arm(40, 1);
    for (int i = 0; i < 40; i++) feed(16'(i));
    check("t3_wc", o_wc, 20);
    check("t3_ovf", {31'd0, o_ovf}, 1);
    ready = 1'b1;
    wait_done("t3_done");
    check("t3_nwords", got.size(), 16);
    check("t3_first", got[0], 32'h00010000);
    check("t3_last", got[15], 32'h001F001E);
    check("t3_ovf_hold", {31'd0, o_ovf}, 1);

    // full FIFO with a pop in the push cycle
    got.delete(); n_done = 0; ready = 1'b0;
    arm(34, 1);
    for (int i = 0; i < 33; i++) feed(16'(i));
    ready = 1'b1;
    feed(16'd33);
    check("t4_ovf", {31'd0, o_ovf}, 0);
    check("t4_wc", o_wc, 17);
    wait_done("t4_done");
    check("t4_nwords", got.size(), 17);
    check("t4_tail", got[16], 32'h00210020);

    // zero parameter start
    n_done = 0;
    arm(0, 5);
    check("t5_done", {31'd0, o_done}, 1);
    check("t5_busy", {31'd0, o_busy}, 0);
    tick();
    check("t5_done_end", {31'd0, o_done}, 0);
    check("t5_done_cnt", n_done, 1);

    // start during busy is ignored
    got.delete(); n_done = 0;
    arm(2, 1);
    feed(16'd7);
    spe = 8; eps = 3; start = 1'b1;
    valid = 1'b1; din = 16'd9;
    tick();
    start = 1'b0; valid = 1'b0;
    wait_done("t6_done");
    check("t6_wc", o_wc, 1);
    check("t6_word", got[0], 32'h00090007);

    // reset in the middle of an echo
    n_done = 0; ready = 1'b0;
    arm(10, 1);
    for (int i = 0; i < 7; i++) feed(16'(i));
    check("t7_pre_valid", {31'd0, o_valid}, 1);
    rst_n = 1'b0;
    tick();
    check("t7_valid", {31'd0, o_valid}, 0);
    check("t7_busy", {31'd0, o_busy}, 0);
    check("t7_ovf", {31'd0, o_ovf}, 0);
    check("t7_done", {31'd0, o_done}, 0);
    rst_n = 1'b1;
    tick();
    got.delete(); ready = 1'b1;
    arm(2, 1);
    feed(16'h0011);
    feed(16'h0022);
    wait_done("t7_done2");
    check("t7_word", got[0], 32'h00220011);

    // randomized scans
    for (int sc = 0; sc < 25; sc++) begin
      n_done = 0;
      ready  = 1'b1;
      arm(32'($urandom_range(1, 9)), 32'($urandom_range(1, 3)));
      for (int k = 0; k < 4000; k++) begin
        if (n_done != 0) break;
        valid = ($urandom % 10) < 7;
        din   = 16'($urandom);
        ready = ($urandom % 10) < ((sc % 3 == 0) ? 2 : 6);
        start = ($urandom % 20) == 0;
        spe   = 32'($urandom_range(0, 9));
        eps   = 32'($urandom_range(0, 3));
        tick();
      end
      start = 1'b0;
      valid = 1'b0;
      check("rnd_done", {31'd0, n_done != 0}, 32'd1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_echo_packer.md
# adc_echo_packer

Receive-side consumer of the NMR controller's ADC sample stream. Accepts 16-bit samples qualified by a valid strobe and frames them into echoes (SAMPLES_PER_ECHO samples, ECHO_PER_SCAN echoes per scan). Packs sample pairs into 32-bit bus words and buffers them in a small FIFO with a ready/valid output toward the host-side DMA/readout logic. Runs entirely in the ADC clock domain.

## Interface
- DATABUS_WIDTH, 32, output word width; must equal 2*ADC_DATA_WIDTH
- ADC_DATA_WIDTH, 16, input sample width
- FIFO_DEPTH, 16, output FIFO depth in words; power of 2, >= 2
- ADC_CLK  in  1  sole clock, rising edge
- RESET_N  in  1  synchronous, active-low reset
- START  in  1  one-cycle arm pulse; latches frame parameters
- SAMPLES_PER_ECHO  in  DATABUS_WIDTH  samples per echo, sampled on START
- ECHO_PER_SCAN  in  DATABUS_WIDTH  echoes per scan, sampled on START
- ADC_IN_DATA  in  ADC_DATA_WIDTH  sample from controller ADC_OUT_DATA
- ADC_IN_VALID  in  1  sample qualifier from controller ADC_DATA_VALID
- OUT_DATA  out  DATABUS_WIDTH  packed word, FIFO head
- OUT_VALID  out  1  FIFO non-empty
- OUT_READY  in  1  downstream accepts word when OUT_VALID & OUT_READY
- BUSY  out  1  high from accepted START until DONE
- DONE  out  1  one-cycle pulse at scan completion
- OVERFLOW  out  1  sticky: a word was dropped on full FIFO
- WORD_COUNT  out  DATABUS_WIDTH  words pushed this scan (including dropped)

## Operation
- States: IDLE, LO, HI, DRAIN.
- IDLE: START with both parameters nonzero -> latch S, E; clear sample/echo counters, WORD_COUNT, OVERFLOW; BUSY=1; -> LO. START with S=0 or E=0 -> DONE pulse next cycle, BUSY stays 0, no words, OVERFLOW cleared.
- START while BUSY: ignored.
- LO, sample valid: hold sample in low register; sample_cnt++. If this is last sample of echo (odd S): push {16'h0000, sample}; echo_cnt++; last echo -> DRAIN else stay LO with sample_cnt=0. Otherwise -> HI.
- HI, sample valid: push {sample, low_reg} (first sample in bits [15:0]); sample_cnt++. End of echo: sample_cnt=0, echo_cnt++; last echo -> DRAIN else LO. Not end -> LO.
- Words per echo = ceil(S/2); echoes never share a word; each echo starts in LO.
- ADC_IN_VALID ignored in IDLE and DRAIN.
- DRAIN: when FIFO empty (after any pop this cycle) -> DONE pulse, BUSY=0, -> IDLE.
- Push on full FIFO: if a pop occurs same cycle, push accepted; else word dropped, OVERFLOW=1, WORD_COUNT still increments, framing continues.
- OVERFLOW held until next accepted START or reset.
- Counters 32-bit unsigned; no wrap within legal parameter range.
- Reset: FIFO flushed, state IDLE, all outputs 0.

## Timing
- Reset values: OUT_DATA 0, OUT_VALID 0, BUSY 0, DONE 0, OVERFLOW 0, WORD_COUNT 0.
- START at edge k -> BUSY high after edge k; first sample accepted at edge k+1 at earliest.
- Push latency: completing sample at edge k -> word in FIFO, OUT_VALID=1 after edge k (first-word-fall-through, OUT_DATA valid same cycle as OUT_VALID).
- Pop: OUT_VALID & OUT_READY at edge k -> next word (or OUT_VALID=0) after edge k.
- Full sustained throughput: one sample per clock in, one word per two clocks out.
- DONE: asserted the cycle after the edge where FIFO becomes empty in DRAIN; exactly one cycle.
- OVERFLOW set after the edge of the dropped push.
- RESET_N low at any edge overrides all activity including mid-scan; DONE not asserted.

## Test plan
- S=4, E=2, samples 100..107 back-to-back, OUT_READY=1 -> words 0x00650064, 0x00670066, 0x00690068, 0x006B006A; DONE once; WORD_COUNT=4.
- S=3, E=2, samples 1..6 -> words 0x00020001, 0x00000003, 0x00050004, 0x00000006; echo 2 starts in low half.
- S=40, E=1, FIFO_DEPTH=16, OUT_READY=0 until ADC stops -> 16 words retained (0x..0001/0000 ordering intact), 4 dropped, OVERFLOW=1, WORD_COUNT=20; raise OUT_READY -> 16 words drained, then DONE.
- FIFO full with OUT_READY=1 at push cycle -> no drop, OVERFLOW stays 0.
- START with S=0 -> DONE next cycle, BUSY never high, OUT_VALID stays 0; START during BUSY -> no effect on counts.
- RESET_N low mid-echo with 3 words buffered -> OUT_VALID=0, BUSY=0, OVERFLOW=0 after that edge; new START runs cleanly.
